alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_if.sv | 24 ++
 rtl/alu_op_sequencer.sv | 102 ++++++++++
 tb/tb_alu_op_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/response channel of the ALU operation sequencer.
// The slave modport is the sequencer; the master modport is the requester/consumer.
interface alu_op_sequencer_if;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  opcode;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        res_valid;
    logic        res_ready;
    logic        illegal;

    modport master (
        output op_valid, opcode, opa, opb, res_ready,
        input  op_ready, z_hi, z_lo, res_valid, illegal
    );

    modport slave (
        input  op_valid, opcode, opa, opb, res_ready,
        output op_ready, z_hi, z_lo, res_valid, illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: latch operands, wait a fixed latency, capture the result.
// Optional macro ALU_SEQ_BACK2BACK_EN lets a new request be accepted on the edge that retires a result.
module alu_op_sequencer #(
    parameter int SIMPLE_WAIT = 1,
    parameter int MULDIV_WAIT = 4
) (
    input  logic               clock,
    input  logic               clear,
    alu_op_sequencer_if.slave  bus,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [13:0]        alu_ctl,
    input  logic [63:0]        alu_result
);
    localparam logic [3:0] SIMPLE_LOAD = 4'(SIMPLE_WAIT - 1);
    localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_WAIT - 1);
    localparam logic [4:0] OP_MUL      = 5'd11;
    localparam logic [4:0] OP_DIV      = 5'd12;
    localparam logic [4:0] OP_LAST     = 5'd13;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        res_valid;
    logic        illegal;
    logic        op_ready;
    logic        accept;
    logic        legal;
    logic [3:0]  wait_load;

`ifdef ALU_SEQ_BACK2BACK_EN
    assign op_ready = (state == IDLE) | ((state == HOLD) & bus.res_ready);
`else
    assign op_ready = (state == IDLE);
`endif

    assign accept    = bus.op_valid & op_ready;
    assign legal     = (bus.opcode <= OP_LAST);
    assign wait_load = ((bus.opcode == OP_MUL) || (bus.opcode == OP_DIV)) ? MULDIV_LOAD : SIMPLE_LOAD;

    assign bus.op_ready  = op_ready;
    assign bus.z_hi      = z_hi;
    assign bus.z_lo      = z_lo;
    assign bus.res_valid = res_valid;
    assign bus.illegal   = illegal;

    // An accept can only happen in IDLE, or in HOLD when the result retires on the same edge.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            count     <= 4'd0;
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            alu_ctl   <= 14'd0;
            z_hi      <= 32'd0;
            z_lo      <= 32'd0;
            res_valid <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            illegal <= 1'b0;
            if (accept) begin
                res_valid <= 1'b0;
                if (legal) begin
                    alu_a   <= bus.opa;
                    alu_b   <= bus.opb;
                    alu_ctl <= 14'd1 << bus.opcode[3:0];
                    count   <= wait_load;
                    state   <= EXEC;
                end else begin
                    illegal <= 1'b1;
                    alu_ctl <= 14'd0;
                    state   <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: ;
                    EXEC: begin
                        if (count == 4'd0) begin
                            z_hi      <= alu_result[63:32];
                            z_lo      <= alu_result[31:0];
                            alu_ctl   <= 14'd0;
                            res_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            count <= count - 4'd1;
                        end
                    end
                    HOLD: begin
                        if (bus.res_ready) begin
                            res_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer against a transaction-level model.
// Expectations follow ALU_SEQ_BACK2BACK_EN when the bench is built with it.
module tb_alu_op_sequencer;
    localparam int SW = 1;
    localparam int MW = 4;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [13:0] alu_ctl;
    logic [63:0] alu_result;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_z = 64'd0;

    always #5 clock = ~clock;

    alu_op_sequencer_if bus();

    alu_op_sequencer #(.SIMPLE_WAIT(SW), .MULDIV_WAIT(MW)) dut (
        .clock      (clock),
        .clear      (clear),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctl    (alu_ctl),
        .alu_result (alu_result)
    );

    // Behavioural ALU: signed MUL, DIV gives remainder in the upper word and quotient in the lower.
    function automatic logic [63:0] alu_model(input int op, input logic [31:0] a, input logic [31:0] b);
        int                 s;
        logic signed [63:0] p;
        s = int'(b[4:0]);
        case (op)
            0:  return {32'd0, a + b};
            1:  return {32'd0, a - b};
            2:  return {32'd0, a & b};
            3:  return {32'd0, a | b};
            4:  return {32'd0, 32'd0 - a};
            5:  return {32'd0, ~a};
            6:  return {32'd0, a >> s};
            7:  return {32'd0, 32'($signed(a) >>> s)};
            8:  return {32'd0, a << s};
            9:  return {32'd0, (a >> s) | (a << (32 - s))};
            10: return {32'd0, (a << s) | (a >> (32 - s))};
            11: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p;
            end
            12: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
            13: return {32'd0, a + 32'd1};
            default: return 64'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = 64'd0;
        for (int i = 0; i < 14; i++)
            if (alu_ctl[i]) alu_result = alu_model(i, alu_a, alu_b);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic test_reset();
        clear = 1'b1;
        bus.op_valid = 1'b0; bus.opcode = 5'd0; bus.opa = 32'd0; bus.opb = 32'd0; bus.res_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        last_z = 64'd0;
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_op_ready got %b exp 1", bus.op_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got %b exp 0", bus.res_valid); end
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal got %b exp 0", bus.illegal); end
        checks++; if ({bus.z_hi, bus.z_lo} !== 64'd0) begin errors++; $display("[TB] FAIL reset_z got %h exp 0", {bus.z_hi, bus.z_lo}); end
        checks++; if ({alu_a, alu_b, alu_ctl} !== 78'd0) begin errors++; $display("[TB] FAIL reset_alu got %h %h %h exp 0", alu_a, alu_b, alu_ctl); end
    endtask

    // One full transaction: accept, latency, capture, hold for 'hold' cycles, retire.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] exp_z;
        int          exp_lat;
        int          lat;
        exp_z   = alu_model(int'(op), a, b);
        exp_lat = (op == 5'd11 || op == 5'd12) ? MW : SW;
        @(negedge clock);
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_op_ready got %b exp 1", bus.op_ready); end
        bus.op_valid = 1'b1; bus.opcode = op; bus.opa = a; bus.opb = b; bus.res_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 20) begin
            checks++; if (alu_ctl !== (14'd1 << op[3:0])) begin errors++; $display("[TB] FAIL exec_alu_ctl op %0d got %h exp %h", op, alu_ctl, 14'd1 << op[3:0]); end
            checks++; if ({alu_a, alu_b} !== {a, b}) begin errors++; $display("[TB] FAIL exec_operands got %h %h exp %h %h", alu_a, alu_b, a, b); end
            bus.op_valid = 1'($urandom); bus.opcode = 5'($urandom); bus.opa = $urandom; bus.opb = $urandom;
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        bus.op_valid = 1'b0;
        checks++; if (lat != exp_lat) begin errors++; $display("[TB] FAIL latency op %0d got %0d exp %0d", op, lat, exp_lat); end
        checks++; if ({bus.z_hi, bus.z_lo} !== exp_z) begin errors++; $display("[TB] FAIL result op %0d got %h exp %h", op, {bus.z_hi, bus.z_lo}, exp_z); end
        checks++; if (alu_ctl !== 14'd0) begin errors++; $display("[TB] FAIL hold_alu_ctl got %h exp 0", alu_ctl); end
        last_z = exp_z;
        for (int i = 0; i < hold; i++) begin
            bus.op_valid = 1'b1; bus.opcode = 5'($urandom_range(0, 13)); bus.opa = $urandom;
            @(posedge clock);
            @(negedge clock);
            checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_res_valid got %b exp 1", bus.res_valid); end
            checks++; if ({bus.z_hi, bus.z_lo} !== exp_z) begin errors++; $display("[TB] FAIL hold_z got %h exp %h", {bus.z_hi, bus.z_lo}, exp_z); end
            checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_op_ready got %b exp 0", bus.op_ready); end
        end
        bus.op_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.res_ready = 1'b0;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL retire_res_valid got %b exp 0", bus.res_valid); end
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("[TB] FAIL retire_op_ready got %b exp 1", bus.op_ready); end
    endtask

    task automatic test_add();
        do_op(5'd0, 32'd5, 32'd7, 0);
        checks++; if ({bus.z_hi, bus.z_lo} !== 64'd12) begin errors++; $display("[TB] FAIL add_5_7 got %h exp 12", {bus.z_hi, bus.z_lo}); end
    endtask

    task automatic test_muldiv();
        do_op(5'd11, 32'hFFFF_FFFF, 32'd2, 0);
        checks++; if ({bus.z_hi, bus.z_lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("[TB] FAIL mul_neg1_2 got %h exp FFFFFFFFFFFFFFFE", {bus.z_hi, bus.z_lo}); end
        do_op(5'd12, 32'd17, 32'd5, 1);
        checks++; if ({bus.z_hi, bus.z_lo} !== {32'd2, 32'd3}) begin errors++; $display("[TB] FAIL div_17_5 got %h exp 0000000200000003", {bus.z_hi, bus.z_lo}); end
    endtask

    task automatic test_hold();
        do_op(5'd1, 32'd10, 32'd3, 3);
        checks++; if (bus.z_lo !== 32'd7) begin errors++; $display("[TB] FAIL sub_retained got %h exp 7", bus.z_lo); end
    endtask

    task automatic test_illegal(input logic [4:0] op);
        @(negedge clock);
        bus.op_valid = 1'b1; bus.opcode = op; bus.opa = $urandom; bus.opb = $urandom;
        @(posedge clock);
        @(negedge clock);
        bus.op_valid = 1'b0;
        checks++; if (bus.illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_pulse op %0d got %b exp 1", op, bus.illegal); end
        checks++; if (alu_ctl !== 14'd0) begin errors++; $display("[TB] FAIL illegal_alu_ctl got %h exp 0", alu_ctl); end
        checks++; if ({bus.z_hi, bus.z_lo} !== last_z) begin errors++; $display("[TB] FAIL illegal_z got %h exp %h", {bus.z_hi, bus.z_lo}, last_z); end
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_op_ready got %b exp 1", bus.op_ready); end
        @(posedge clock);
        @(negedge clock);
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("[TB] FAIL illegal_one_cycle got %b exp 0", bus.illegal); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL illegal_res_valid got %b exp 0", bus.res_valid); end
    endtask

    task automatic test_clear_mid();
        @(negedge clock);
        bus.op_valid = 1'b1; bus.opcode = 5'd12; bus.opa = 32'd100; bus.opb = 32'd7;
        @(posedge clock);
        @(negedge clock);
        bus.op_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        last_z = 64'd0;
        checks++; if ({alu_a, alu_b, alu_ctl} !== 78'd0) begin errors++; $display("[TB] FAIL clear_exec_alu got %h %h %h exp 0", alu_a, alu_b, alu_ctl); end
        checks++; if ({bus.z_hi, bus.z_lo} !== 64'd0) begin errors++; $display("[TB] FAIL clear_exec_z got %h exp 0", {bus.z_hi, bus.z_lo}); end
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("[TB] FAIL clear_exec_op_ready got %b exp 1", bus.op_ready); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_exec_res_valid cycle %0d got %b exp 0", i, bus.res_valid); end
            @(posedge clock);
            @(negedge clock);
        end
        // Clear while a result is being held
        bus.op_valid = 1'b1; bus.opcode = 5'd0; bus.opa = 32'd1; bus.opb = 32'd2;
        @(posedge clock);
        @(negedge clock);
        bus.op_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_clear_hold got %b exp 1", bus.res_valid); end
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        checks++; if ({bus.res_valid, bus.z_hi, bus.z_lo} !== 65'd0) begin errors++; $display("[TB] FAIL clear_hold got %b %h exp 0", bus.res_valid, {bus.z_hi, bus.z_lo}); end
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("[TB] FAIL clear_hold_op_ready got %b exp 1", bus.op_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        int          n;
        int          exp_n;
        logic        pending;
        logic        sent;
        logic        exp_ready;
        a = $urandom;
`ifdef ALU_SEQ_BACK2BACK_EN
        exp_n = 2; exp_ready = 1'b1;
`else
        exp_n = 3; exp_ready = 1'b0;
`endif
        @(negedge clock);
        bus.op_valid = 1'b1; bus.opcode = 5'd0; bus.opa = 32'd3; bus.opb = 32'd4; bus.res_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bus.op_valid = 1'b0;
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 20) begin
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        checks++; if (bus.z_lo !== 32'd7) begin errors++; $display("[TB] FAIL b2b_add got %h exp 7", bus.z_lo); end
        bus.res_ready = 1'b1; bus.op_valid = 1'b1; bus.opcode = 5'd5; bus.opa = a; bus.opb = 32'd0;
        checks++; if (bus.op_ready !== exp_ready) begin errors++; $display("[TB] FAIL b2b_hold_op_ready got %b exp %b", bus.op_ready, exp_ready); end
        pending = 1'b1;
        sent = bus.op_ready;
        n = 0;
        do begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (pending && sent) begin
                pending = 1'b0;
                bus.op_valid = 1'b0;
            end
            sent = bus.op_ready;
        end while (bus.res_valid !== 1'b1 && n < 20);
        checks++; if (n != exp_n) begin errors++; $display("[TB] FAIL b2b_interval got %0d exp %0d", n, exp_n); end
        checks++; if ({bus.z_hi, bus.z_lo} !== {32'd0, ~a}) begin errors++; $display("[TB] FAIL b2b_not got %h exp %h", {bus.z_hi, bus.z_lo}, {32'd0, ~a}); end
        last_z = {32'd0, ~a};
        bus.op_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bus.res_ready = 1'b0;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_retire got %b exp 0", bus.res_valid); end
    endtask

    task automatic test_random();
        int          sel;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (sel >= 14) begin
                op = 5'($urandom_range(14, 31));
                test_illegal(op);
            end else begin
                op = 5'(sel);
                if (op == 5'd12) begin
                    a = a >> 1;
                    if (b == 32'd0) b = 32'd1;
                end
                do_op(op, a, b, int'($urandom_range(0, 3)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_muldiv();
        test_hold();
        test_illegal(5'd20);
        test_clear_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
